// File: rtl/uart_seg_pkg.sv
// Shared constants, buffer entry type and byte classifier for the UART-driven
// seven-segment scanner.
package uart_seg_pkg;

  localparam logic [7:0] BS  = 8'h08;
  localparam logic [7:0] ESC = 8'h1B;
  localparam logic [7:0] CR  = 8'h0D;
  localparam logic [7:0] LF  = 8'h0A;
  localparam logic [7:0] DOT = 8'h2E;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] EN_OFF    = 8'hFF;

  // Active-low g..a patterns, index = nibble value
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic       vld;
    logic [3:0] nib;
    logic       dp;
  } seg_ent_t;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_HEX,
    CMD_DOT,
    CMD_BS,
    CMD_ESC,
    CMD_BAD
  } cmd_e;

  function automatic cmd_e classify(logic [7:0] c);
    cmd_e r;
    if ((c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
        (c >= 8'h61 && c <= 8'h66))
      r = CMD_HEX;
    else if (c == DOT)
      r = CMD_DOT;
    else if (c == BS)
      r = CMD_BS;
    else if (c == ESC)
      r = CMD_ESC;
    else if (c == CR || c == LF)
      r = CMD_NONE;
    else
      r = CMD_BAD;
    return r;
  endfunction

  // Letters share the low nibble layout 1..6 for A..F / a..f
  function automatic logic [3:0] hex_nib(logic [7:0] c);
    logic [3:0] r;
    if (c <= 8'h39) r = c[3:0];
    else            r = c[3:0] + 4'd9;
    return r;
  endfunction

endpackage

// File: rtl/uart_seg_scan_if.sv
// Byte-stream input and scanned display outputs of uart_seg_scan.
interface uart_seg_scan_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] en;
  logic [7:0] seg_data;
  logic [3:0] digit_count;
  logic       char_err;

  modport master (
    output rx_data, rx_valid,
    input  en, seg_data, digit_count, char_err
  );

  modport slave (
    input  rx_data, rx_valid,
    output en, seg_data, digit_count, char_err
  );
endinterface

// File: rtl/uart_seg_scan_hex.sv
// Nibble to active-low seven-segment pattern lookup.
module seg_hex_decode
  import uart_seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  assign o_seg = SEG_LUT[i_nib];
endmodule

// File: rtl/uart_seg_scan.sv
// Scrolling 8-digit hex buffer fed by received ASCII bytes, time-multiplexed
// onto a shared active-low seven-segment bus with a blanking gap per slot.
module uart_seg_scan
  import uart_seg_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 500,
  parameter int LEAD_BLANK = 1
) (
  input  logic           clk,
  input  logic           rst,
  uart_seg_scan_if.slave bus
);

  localparam logic [15:0] PRE_MAX = 16'(SCAN_DIV - 1);
  localparam logic [15:0] BLANK   = 16'(BLANK_CYC);

  seg_ent_t [7:0] r_buf;
  logic [3:0]     r_cnt;
  logic           r_err;
  logic [15:0]    r_pre;
  logic [2:0]     r_idx;
  logic [7:0]     r_en;
  logic [7:0]     r_seg;

  cmd_e           w_cmd;
  seg_ent_t       w_ent;
  logic [6:0]     w_hex;
  logic [6:0]     w_pat;

  assign w_cmd = bus.rx_valid ? classify(bus.rx_data) : CMD_NONE;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_buf <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= (w_cmd == CMD_BAD);
      case (w_cmd)
        CMD_HEX: begin
          r_buf <= {r_buf[6:0], seg_ent_t'{1'b1, hex_nib(bus.rx_data), 1'b0}};
          if (r_cnt != 4'd8) r_cnt <= r_cnt + 4'd1;
        end
        CMD_DOT: r_buf[0].dp <= 1'b1;
        CMD_BS: begin
          // Empty buffer is left alone, so a lone dp on entry0 survives
          if (r_cnt != 4'd0) begin
            r_buf <= {seg_ent_t'('0), r_buf[7:1]};
            r_cnt <= r_cnt - 4'd1;
          end
        end
        CMD_ESC: begin
          r_buf <= '0;
          r_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (r_pre == PRE_MAX) begin
      r_pre <= '0;
      r_idx <= r_idx + 3'd1;
    end else begin
      r_pre <= r_pre + 16'd1;
    end
  end

  assign w_ent = r_buf[r_idx];

  seg_hex_decode u_hex (
    .i_nib (w_ent.nib),
    .o_seg (w_hex)
  );

  assign w_pat = w_ent.vld ? w_hex : ((LEAD_BLANK != 0) ? 7'h7F : SEG_LUT[0]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_en  <= EN_OFF;
      r_seg <= SEG_BLANK;
    end else if (r_pre < BLANK) begin
      r_en  <= EN_OFF;
      r_seg <= SEG_BLANK;
    end else begin
      r_en  <= ~(8'd1 << r_idx);
      r_seg <= {~w_ent.dp, w_pat};
    end
  end

  assign bus.en          = r_en;
  assign bus.seg_data    = r_seg;
  assign bus.digit_count = r_cnt;
  assign bus.char_err    = r_err;

endmodule
